// File: rtl/cpu_int_pkg.sv
// Shared types and constants for the 65HE06 interrupt / front-end status controller.
// Holds FSM state encoding, interrupt source IDs, injected opcodes and vector offsets.
package cpu_int_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_VECTOR   = 3'd1,
    ST_SKIP     = 3'd2,
    ST_RUN      = 3'd3,
    ST_WAIT_SF  = 3'd4,
    ST_WAIT_INT = 3'd6,
    ST_WAIT_RST = 3'd7
  } state_e;

  localparam int SRC_W = 4;
  typedef logic [SRC_W-1:0] src_t;

  localparam src_t SRC_RST  = 4'd0;
  localparam src_t SRC_NMI  = 4'd1;
  localparam src_t SRC_BRK  = 4'd2;
  localparam src_t SRC_IRQ0 = 4'd3;

  localparam logic [15:0] IR_RST = 16'h132C;
  localparam logic [15:0] IR_VEC = 16'h8322;

  localparam logic [3:0] VOFS_RST  = 4'hC;
  localparam logic [3:0] VOFS_NMI  = 4'hA;
  localparam logic [3:0] VOFS_BRK  = 4'h8;
  localparam logic [3:0] VOFS_IRQ0 = 4'hE;
  localparam logic [3:0] VOFS_IRQN = 4'h0;

  // irq[k>=1] vectors grow downward two bytes per line below {VEC_HI,0}
  function automatic logic [15:0] vec_addr(input logic [11:0] vec_hi, input src_t src);
    logic [15:0] k;
    k        = 16'(src - SRC_IRQ0);
    vec_addr = {vec_hi, VOFS_IRQN} - ((k - 16'd1) << 1);
    case (src)
      SRC_RST:  vec_addr = {vec_hi, VOFS_RST};
      SRC_NMI:  vec_addr = {vec_hi, VOFS_NMI};
      SRC_BRK:  vec_addr = {vec_hi, VOFS_BRK};
      SRC_IRQ0: vec_addr = {vec_hi, VOFS_IRQ0};
      default:  ;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sf_scoreboard.sv
// One status-flag busy group: set by busy, cleared by ready; busy wins a same-cycle race.
// Latency: status visible the cycle after the busy/ready strobe.
module cpu_sf_scoreboard
  import cpu_int_pkg::*;
(
  input  logic clk,
  input  logic a_rst,
  input  logic sf_busy_i,
  input  logic sf_rdy_i,
  output logic sf_status_o
);

  logic status_q, status_d;

  assign status_d    = status_q ? (~sf_rdy_i | sf_busy_i) : sf_busy_i;
  assign sf_status_o = status_q;

  always_ff @(posedge clk) begin
    if (a_rst) status_q <= 1'b0;
    else       status_q <= status_d;
  end

endmodule

// File: rtl/cpu_int_ctrl.sv
// Interrupt entry / WAI / STP / flag-stall controller between decode and fetch of the 65HE06.
// Optional CPU_INT_NMI_EDGE_EN: edge-detected, latched NMI instead of level-sensitive NMI.
module cpu_int_ctrl
  import cpu_int_pkg::*;
#(
  parameter int          IRQ_LINES = 4,
  parameter int          SF_GROUPS = 2,
  parameter logic [11:0] VEC_HI    = 12'hFFF
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 nmi,
  input  logic [IRQ_LINES-1:0] irq,
  input  logic                 brk,
  input  logic                 rst,
  input  logic                 ien_we,
  input  logic [IRQ_LINES-1:0] ien_d,
  input  logic                 op_wai,
  input  logic                 op_stp,
  input  logic                 op_rti,
  input  logic                 op_sei,
  input  logic                 op_cli,
  input  logic                 feed_ack,
  input  logic [SF_GROUPS-1:0] sf_query,
  input  logic [SF_GROUPS-1:0] sf_busy,
  input  logic [SF_GROUPS-1:0] sf_rdy,
  output logic [15:0]          int_ir,
  output logic [15:0]          int_k,
  output logic                 replace_ir,
  output logic                 replace_k,
  output logic                 hold_fetch,
  output logic                 hold_decode,
  output logic                 nmi_ack,
  output logic [IRQ_LINES-1:0] irq_ack,
  output logic                 i_flag
);

  state_e               state_q, state_d;
  src_t                 src_q, src_d;
  logic                 i_flag_q, i_flag_d;
  logic [IRQ_LINES-1:0] ien_q, ien_nxt;
  logic [SF_GROUPS-1:0] qmask_q, qmask_d;
  logic [SF_GROUPS-1:0] sf_status;

  logic [IRQ_LINES-1:0] pend_irq, irq_win;
  src_t                 irq_src, win_src;
  logic                 nmi_p, take, stall, sf_clear;
  logic                 enter_vec, ack_en;

  for (genvar g = 0; g < SF_GROUPS; g++) begin : g_sf
    cpu_sf_scoreboard u_sb (
      .clk         (clk),
      .a_rst       (a_rst),
      .sf_busy_i   (sf_busy[g]),
      .sf_rdy_i    (sf_rdy[g]),
      .sf_status_o (sf_status[g])
    );
  end

`ifdef CPU_INT_NMI_EDGE_EN
  logic nmi_prev_q, nmi_pend_q, nmi_rise;

  assign nmi_rise = nmi & ~nmi_prev_q;
  assign nmi_p    = nmi_pend_q | nmi_rise;

  // Pending is dropped only by an actual NMI acceptance, so short pulses survive stalls
  always_ff @(posedge clk) begin
    if (a_rst) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi;
      nmi_pend_q <= (nmi_pend_q | nmi_rise) & ~nmi_ack;
    end
  end
`else
  assign nmi_p = nmi;
`endif

  assign pend_irq = irq & ien_q & {IRQ_LINES{~i_flag_q}};
  assign take     = rst | nmi_p | brk | (|pend_irq);
  assign stall    = |(sf_status & sf_query);
  assign sf_clear = ~|(sf_status & qmask_q);

  // Descending scan so the lowest-numbered pending line wins
  always_comb begin
    irq_win = '0;
    irq_src = SRC_IRQ0;
    for (int k = IRQ_LINES - 1; k >= 0; k--) begin
      if (pend_irq[k]) begin
        irq_win    = '0;
        irq_win[k] = 1'b1;
        irq_src    = SRC_IRQ0 + src_t'(k);
      end
    end
  end

  always_comb begin
    win_src = irq_src;
    if (rst)        win_src = SRC_RST;
    else if (nmi_p) win_src = SRC_NMI;
    else if (brk)   win_src = SRC_BRK;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:    state_d = ST_VECTOR;
      ST_VECTOR:   if (feed_ack) state_d = ST_SKIP;
      ST_SKIP:     if (feed_ack) state_d = ST_RUN;
      ST_RUN: begin
        if (stall)                 state_d = ST_WAIT_SF;
        else if (take && feed_ack) state_d = ST_VECTOR;
        else if (op_stp)           state_d = ST_WAIT_RST;
        else if (op_wai)           state_d = ST_WAIT_INT;
      end
      ST_WAIT_SF:  if (sf_clear) state_d = ST_RUN;
      ST_WAIT_INT: if (take)     state_d = ST_VECTOR;
      ST_WAIT_RST: if (rst)      state_d = ST_VECTOR;
      default:     state_d = ST_RESET;
    endcase
    if (a_rst) state_d = ST_RESET;
  end

  assign enter_vec = (state_d == ST_VECTOR) && (state_q != ST_VECTOR);
  // Leaving RESET always vectors through RST and never acknowledges a source
  assign ack_en    = enter_vec && (state_q != ST_RESET);

  assign nmi_ack = ack_en && (win_src == SRC_NMI);
  assign irq_ack = (ack_en && (win_src >= SRC_IRQ0)) ? irq_win : '0;

  always_comb begin
    src_d = src_q;
    if (enter_vec) src_d = (state_q == ST_RESET) ? SRC_RST : win_src;
  end

  always_comb begin
    i_flag_d = i_flag_q;
    if (enter_vec || op_sei)    i_flag_d = 1'b1;
    else if (op_cli || op_rti)  i_flag_d = 1'b0;
  end

  assign ien_nxt = ien_we ? ien_d : ien_q;
  assign qmask_d = ((state_q == ST_RUN) && (state_d == ST_WAIT_SF)) ? sf_query : qmask_q;

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_q  <= ST_RESET;
      src_q    <= SRC_RST;
      i_flag_q <= 1'b1;
      ien_q    <= '0;
      qmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      i_flag_q <= i_flag_d;
      ien_q    <= ien_nxt;
      qmask_q  <= qmask_d;
    end
  end

  assign int_ir      = (src_q == SRC_RST) ? IR_RST : IR_VEC;
  assign int_k       = vec_addr(VEC_HI, src_q);
  assign replace_ir  = (state_q == ST_VECTOR);
  assign replace_k   = (state_q == ST_VECTOR);
  assign hold_fetch  = (state_d != ST_RUN);
  assign hold_decode = (state_d != ST_VECTOR) && (state_d != ST_RUN);
  assign i_flag      = i_flag_q;

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed self-checking bench for cpu_int_ctrl; inputs change 1 time unit after the rising edge.
module tb_cpu_int_ctrl;

  logic        clk;
  logic        a_rst;
  logic        nmi, brk, rst, ien_we;
  logic [3:0]  irq, ien_d;
  logic        op_wai, op_stp, op_rti, op_sei, op_cli, feed_ack;
  logic [1:0]  sf_query, sf_busy, sf_rdy;
  logic [15:0] int_ir, int_k;
  logic        replace_ir, replace_k, hold_fetch, hold_decode, nmi_ack, i_flag;
  logic [3:0]  irq_ack;

  int total = 0;
  int bad   = 0;

  cpu_int_ctrl #(.IRQ_LINES(4), .SF_GROUPS(2), .VEC_HI(12'hFFF)) dut (
    .clk(clk), .a_rst(a_rst), .nmi(nmi), .irq(irq), .brk(brk), .rst(rst),
    .ien_we(ien_we), .ien_d(ien_d), .op_wai(op_wai), .op_stp(op_stp),
    .op_rti(op_rti), .op_sei(op_sei), .op_cli(op_cli), .feed_ack(feed_ack),
    .sf_query(sf_query), .sf_busy(sf_busy), .sf_rdy(sf_rdy),
    .int_ir(int_ir), .int_k(int_k), .replace_ir(replace_ir), .replace_k(replace_k),
    .hold_fetch(hold_fetch), .hold_decode(hold_decode), .nmi_ack(nmi_ack),
    .irq_ack(irq_ack), .i_flag(i_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    feed_ack = 1'b1;
    cyc();
    cyc();
    feed_ack = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    cyc();
    cyc();
    total++; if (hold_fetch !== 1'b1) begin bad++; $display("FAIL rst_hold_fetch got=%b want=1", hold_fetch); end
    total++; if (hold_decode !== 1'b1) begin bad++; $display("FAIL rst_hold_decode got=%b want=1", hold_decode); end
    total++; if (i_flag !== 1'b1) begin bad++; $display("FAIL rst_i_flag got=%b want=1", i_flag); end
    total++; if (replace_ir !== 1'b0 || replace_k !== 1'b0) begin bad++; $display("FAIL rst_replace got=%b%b want=00", replace_ir, replace_k); end
    total++; if (nmi_ack !== 1'b0 || irq_ack !== 4'b0) begin bad++; $display("FAIL rst_acks got=%b/%b want=0/0000", nmi_ack, irq_ack); end
    total++; if (int_ir !== 16'h132C || int_k !== 16'hFFFC) begin bad++; $display("FAIL rst_irk got=%h/%h want=132c/fffc", int_ir, int_k); end
    a_rst = 1'b0;
    #1;
    total++; if (hold_decode !== 1'b0 || hold_fetch !== 1'b1) begin bad++; $display("FAIL rst_exit_holds got=%b%b want=10", hold_fetch, hold_decode); end
    cyc();
    total++; if (replace_ir !== 1'b1 || replace_k !== 1'b1) begin bad++; $display("FAIL rst_vec_replace got=%b%b want=11", replace_ir, replace_k); end
    total++; if (int_k !== 16'hFFFC || int_ir !== 16'h132C) begin bad++; $display("FAIL rst_vec_irk got=%h/%h want=132c/fffc", int_ir, int_k); end
    feed_ack = 1'b1;
    #1;
    total++; if (hold_decode !== 1'b1) begin bad++; $display("FAIL vec_to_skip_hold_decode got=%b want=1", hold_decode); end
    cyc();
    total++; if (hold_fetch !== 1'b0) begin bad++; $display("FAIL skip_to_run_hold_fetch got=%b want=0", hold_fetch); end
    cyc();
    feed_ack = 1'b0;
    #1;
    total++; if (hold_fetch !== 1'b0 || hold_decode !== 1'b0) begin bad++; $display("FAIL run_holds got=%b%b want=00", hold_fetch, hold_decode); end
  endtask

  task automatic test_irq_priority();
    ien_we = 1'b1; ien_d = 4'b1111; op_cli = 1'b1;
    cyc();
    ien_we = 1'b0; op_cli = 1'b0;
    #1;
    total++; if (i_flag !== 1'b0) begin bad++; $display("FAIL cli_i_flag got=%b want=0", i_flag); end
    irq = 4'b0110; feed_ack = 1'b1;
    #1;
    total++; if (irq_ack !== 4'b0010 || nmi_ack !== 1'b0) begin bad++; $display("FAIL irq_prio_ack got=%b/%b want=0010/0", irq_ack, nmi_ack); end
    total++; if (hold_fetch !== 1'b1 || hold_decode !== 1'b0) begin bad++; $display("FAIL irq_entry_holds got=%b%b want=10", hold_fetch, hold_decode); end
    cyc();
    irq = 4'b0; feed_ack = 1'b0;
    #1;
    total++; if (int_k !== 16'hFFF0 || int_ir !== 16'h8322) begin bad++; $display("FAIL irq1_vec got=%h/%h want=8322/fff0", int_ir, int_k); end
    total++; if (i_flag !== 1'b1) begin bad++; $display("FAIL irq_entry_i_flag got=%b want=1", i_flag); end
    total++; if (irq_ack !== 4'b0) begin bad++; $display("FAIL irq_ack_pulse got=%b want=0000", irq_ack); end
    go_run();
  endtask

  task automatic test_nmi_over_irq();
    op_cli = 1'b1;
    cyc();
    op_cli = 1'b0;
    nmi = 1'b1; irq = 4'b0001; feed_ack = 1'b1;
    #1;
    total++; if (nmi_ack !== 1'b1 || irq_ack !== 4'b0) begin bad++; $display("FAIL nmi_over_irq_ack got=%b/%b want=1/0000", nmi_ack, irq_ack); end
    cyc();
    nmi = 1'b0; irq = 4'b0; feed_ack = 1'b0;
    #1;
    total++; if (nmi_ack !== 1'b0) begin bad++; $display("FAIL nmi_ack_once got=%b want=0", nmi_ack); end
    total++; if (int_k !== 16'hFFFA || int_ir !== 16'h8322) begin bad++; $display("FAIL nmi_vec got=%h/%h want=8322/fffa", int_ir, int_k); end
    go_run();
  endtask

  task automatic test_brk();
    brk = 1'b1; feed_ack = 1'b1;
    #1;
    total++; if (nmi_ack !== 1'b0 || irq_ack !== 4'b0 || hold_decode !== 1'b0) begin bad++; $display("FAIL brk_entry got=%b/%b/%b want=0/0000/0", nmi_ack, irq_ack, hold_decode); end
    cyc();
    brk = 1'b0; feed_ack = 1'b0;
    #1;
    total++; if (int_k !== 16'hFFF8 || int_ir !== 16'h8322) begin bad++; $display("FAIL brk_vec got=%h/%h want=8322/fff8", int_ir, int_k); end
    go_run();
  endtask

  task automatic test_flag_stall();
    sf_busy = 2'b01;
    cyc();
    sf_rdy = 2'b01;
    cyc();
    sf_busy = 2'b00; sf_rdy = 2'b00; sf_query = 2'b01;
    #1;
    total++; if (hold_decode !== 1'b1) begin bad++; $display("FAIL busy_rdy_race got=%b want=1", hold_decode); end
    cyc();
    sf_query = 2'b00; sf_rdy = 2'b01;
    cyc();
    sf_rdy = 2'b00;
    #1;
    total++; if (hold_fetch !== 1'b0) begin bad++; $display("FAIL race_release got=%b want=0", hold_fetch); end
    cyc();
    sf_busy = 2'b10;
    cyc();
    sf_busy = 2'b00; sf_query = 2'b10;
    #1;
    total++; if (hold_decode !== 1'b1 || hold_fetch !== 1'b1) begin bad++; $display("FAIL stall_entry got=%b%b want=11", hold_fetch, hold_decode); end
    cyc();
    sf_query = 2'b00;
    #1;
    total++; if (hold_decode !== 1'b1) begin bad++; $display("FAIL stall_hold got=%b want=1", hold_decode); end
    sf_rdy = 2'b10;
    #1;
    total++; if (hold_fetch !== 1'b1) begin bad++; $display("FAIL stall_rdy_same_cycle got=%b want=1", hold_fetch); end
    cyc();
    sf_rdy = 2'b00;
    #1;
    total++; if (hold_fetch !== 1'b0 || hold_decode !== 1'b0) begin bad++; $display("FAIL stall_exit got=%b%b want=00", hold_fetch, hold_decode); end
    cyc();
  endtask

  task automatic test_wai();
    op_wai = 1'b1;
    #1;
    total++; if (hold_fetch !== 1'b1 || hold_decode !== 1'b1) begin bad++; $display("FAIL wai_entry got=%b%b want=11", hold_fetch, hold_decode); end
    cyc();
    op_wai = 1'b0; irq = 4'b0100;
    #1;
    total++; if (irq_ack !== 4'b0 || hold_decode !== 1'b1) begin bad++; $display("FAIL wai_masked got=%b/%b want=0000/1", irq_ack, hold_decode); end
    cyc();
    total++; if (hold_decode !== 1'b1) begin bad++; $display("FAIL wai_stays got=%b want=1", hold_decode); end
    irq = 4'b0; nmi = 1'b1;
    #1;
    total++; if (nmi_ack !== 1'b1 || hold_decode !== 1'b0) begin bad++; $display("FAIL wai_nmi_wake got=%b/%b want=1/0", nmi_ack, hold_decode); end
    cyc();
    nmi = 1'b0;
    #1;
    total++; if (int_k !== 16'hFFFA || replace_k !== 1'b1) begin bad++; $display("FAIL wai_nmi_vec got=%h/%b want=fffa/1", int_k, replace_k); end
    go_run();
  endtask

  task automatic test_stp_rst();
    op_stp = 1'b1;
    #1;
    total++; if (hold_fetch !== 1'b1) begin bad++; $display("FAIL stp_entry got=%b want=1", hold_fetch); end
    cyc();
    op_stp = 1'b0; brk = 1'b1;
    #1;
    total++; if (hold_decode !== 1'b1) begin bad++; $display("FAIL stp_ignores_brk got=%b want=1", hold_decode); end
    brk = 1'b0; rst = 1'b1;
    #1;
    total++; if (hold_decode !== 1'b0 || nmi_ack !== 1'b0 || irq_ack !== 4'b0) begin bad++; $display("FAIL stp_rst_wake got=%b/%b/%b want=0/0/0000", hold_decode, nmi_ack, irq_ack); end
    cyc();
    rst = 1'b0;
    #1;
    total++; if (int_k !== 16'hFFFC || int_ir !== 16'h132C) begin bad++; $display("FAIL soft_rst_vec got=%h/%h want=132c/fffc", int_ir, int_k); end
    go_run();
  endtask

  task automatic test_irq3_midreset();
    ien_we = 1'b1; ien_d = 4'b0111; op_cli = 1'b1;
    cyc();
    ien_we = 1'b0; op_cli = 1'b0;
    irq = 4'b1000; feed_ack = 1'b1;
    #1;
    total++; if (irq_ack !== 4'b0 || hold_fetch !== 1'b0) begin bad++; $display("FAIL ien_masks_irq3 got=%b/%b want=0000/0", irq_ack, hold_fetch); end
    ien_we = 1'b1; ien_d = 4'b1000;
    cyc();
    ien_we = 1'b0;
    #1;
    total++; if (irq_ack !== 4'b1000) begin bad++; $display("FAIL irq3_ack got=%b want=1000", irq_ack); end
    cyc();
    irq = 4'b0; feed_ack = 1'b0;
    #1;
    total++; if (int_k !== 16'hFFEC) begin bad++; $display("FAIL irq3_vec got=%h want=ffec", int_k); end
    a_rst = 1'b1;
    cyc();
    total++; if (replace_ir !== 1'b0 || hold_fetch !== 1'b1 || i_flag !== 1'b1) begin bad++; $display("FAIL midrst_state got=%b/%b/%b want=0/1/1", replace_ir, hold_fetch, i_flag); end
    total++; if (int_k !== 16'hFFFC || int_ir !== 16'h132C) begin bad++; $display("FAIL midrst_src got=%h/%h want=132c/fffc", int_ir, int_k); end
    a_rst = 1'b0;
    cyc();
    go_run();
    op_cli = 1'b1;
    cyc();
    op_cli = 1'b0;
    irq = 4'b0001; feed_ack = 1'b1;
    #1;
    total++; if (irq_ack !== 4'b0 || hold_fetch !== 1'b0) begin bad++; $display("FAIL midrst_ien_cleared got=%b/%b want=0000/0", irq_ack, hold_fetch); end
    irq = 4'b0; feed_ack = 1'b0;
    cyc();
  endtask

`ifdef CPU_INT_NMI_EDGE_EN
  task automatic test_edge_nmi();
    sf_busy = 2'b10;
    cyc();
    sf_busy = 2'b00; sf_query = 2'b10;
    cyc();
    sf_query = 2'b00; nmi = 1'b1;
    cyc();
    nmi = 1'b0;
    #1;
    total++; if (hold_decode !== 1'b1 || nmi_ack !== 1'b0) begin bad++; $display("FAIL edge_nmi_stalled got=%b/%b want=1/0", hold_decode, nmi_ack); end
    sf_rdy = 2'b10;
    cyc();
    sf_rdy = 2'b00;
    cyc();
    feed_ack = 1'b1;
    #1;
    total++; if (nmi_ack !== 1'b1) begin bad++; $display("FAIL edge_nmi_kept got=%b want=1", nmi_ack); end
    cyc();
    feed_ack = 1'b0;
    #1;
    total++; if (int_k !== 16'hFFFA) begin bad++; $display("FAIL edge_nmi_vec got=%h want=fffa", int_k); end
    go_run();
  endtask
`endif

  initial begin
    a_rst = 1'b1; nmi = 1'b0; irq = 4'b0; brk = 1'b0; rst = 1'b0;
    ien_we = 1'b0; ien_d = 4'b0;
    op_wai = 1'b0; op_stp = 1'b0; op_rti = 1'b0; op_sei = 1'b0; op_cli = 1'b0;
    feed_ack = 1'b0; sf_query = 2'b0; sf_busy = 2'b0; sf_rdy = 2'b0;
    #1;
    test_reset();
    test_irq_priority();
    test_nmi_over_irq();
    test_brk();
    test_flag_stall();
    test_wai();
    test_stp_rst();
    test_irq3_midreset();
`ifdef CPU_INT_NMI_EDGE_EN
    test_edge_nmi();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_int_ctrl.md
# cpu_int_ctrl

Parametrised interrupt and front-end status controller for the 65HE06 core. It replaces the single-IRQ status block with the following features:
- `IRQ_LINES` prioritised, individually enabled IRQ inputs with per-line vectors.
- `SF_GROUPS` independent busy-flag scoreboards.
- An explicit I flag with SEI/CLI/RTI control.

It sits between decode and fetch. It injects the vector-jump IR/K pair and holds the front end during interrupt entry, WAI, STP and flag stalls.

## Interface
- `IRQ_LINES`, 4, number of maskable IRQ inputs (1..8)
- `SF_GROUPS`, 2, number of independent status-flag busy groups (1..4)
- `VEC_HI`, 12'hFFF, upper 12 bits of every vector address
- `clk`  in  1  clock; all state updates on the rising edge
- `a_rst`  in  1  reset; synchronous, active-high
- `nmi`  in  1  non-maskable interrupt request
- `irq`  in  IRQ_LINES  maskable requests; bit 0 has the highest priority
- `brk`  in  1  BRK instruction request
- `rst`  in  1  soft reset request
- `ien_we`  in  1  write strobe for the per-line enable register
- `ien_d`  in  IRQ_LINES  enable register write data
- `op_wai`, `op_stp`, `op_rti`, `op_sei`, `op_cli`  in  1 each  decoded control opcodes
- `feed_ack`  in  1  decode consumed the current IR/K
- `sf_query`  in  SF_GROUPS  decode reads the group's flags
- `sf_busy`  in  SF_GROUPS  group goes busy
- `sf_rdy`  in  SF_GROUPS  group busy cleared
- `int_ir`  out  16  injected IR
- `int_k`  out  16  injected vector address
- `replace_ir`, `replace_k`  out  1  select injected IR/K
- `hold_fetch`, `hold_decode`  out  1  front-end stalls
- `nmi_ack`  out  1  NMI accepted
- `irq_ack`  out  IRQ_LINES  one-hot IRQ accepted
- `i_flag`  out  1  global IRQ mask

## Operation
- **States:** RESET(0), VECTOR(1), SKIP(2), RUN(3), WAIT_SF(4), WAIT_INT(6), WAIT_RST(7). Encoding 5 is unused and returns to RESET.
- **Transitions:**
  - RESET → VECTOR unconditionally.
  - VECTOR → SKIP on `feed_ack`.
  - SKIP → RUN on `feed_ack`.
  - RUN, in priority order:
    - `stall` → WAIT_SF.
    - `take & feed_ack` → VECTOR.
    - `op_stp` → WAIT_RST.
    - `op_wai` → WAIT_INT.
  - WAIT_SF → RUN when every group in the latched query mask has `sf_status` = 0.
  - WAIT_INT → VECTOR on `take`.
  - WAIT_RST → VECTOR on `rst`.
- **Pending and stall terms:**
  - `pend_irq = irq & ien & {IRQ_LINES{~i_flag}}`.
  - `take = rst | nmi_p | brk | (|pend_irq)`, where `nmi_p` is the NMI request as qualified by the Configuration macro.
  - `sf_status[g]` next = `sf_status[g] ? (~sf_rdy[g] | sf_busy[g]) : sf_busy[g]`.
  - `stall = |(sf_status & sf_query)`. The query mask is latched on entry to WAIT_SF.
- **Source capture:** on the edge into VECTOR, the winning source is latched with priority rst > nmi > brk > irq[0] > … > irq[N-1].
- **Vectors:**
  - RST = {VEC_HI,4'hC}.
  - NMI = {VEC_HI,4'hA}.
  - BRK = {VEC_HI,4'h8}.
  - irq[0] = {VEC_HI,4'hE}.
  - irq[k], k≥1 = {VEC_HI,4'h0} − 2·(k−1), computed in 16-bit arithmetic.
- **Injected IR:** `int_ir` = 16'h132C for RST, 16'h8322 for all other sources.
- **I flag:**
  - Set on entry to VECTOR and on `op_sei`.
  - Cleared by `op_cli` or `op_rti`. If a clear coincides with entry, entry wins.
- **Enable register `ien`:** loaded from `ien_d` on `ien_we`.
- **Reset values:**
  - state = RESET, so `hold_fetch` = 1 and `hold_decode` = 1 in the reset cycle.
  - `i_flag` = 1, `ien` = 0, `sf_status` = 0.
  - All acks = 0, `replace_*` = 0.
  - Latched source = RST, so `int_ir` = 16'h132C and `int_k` = {VEC_HI,4'hC}.
- **Reset mid-operation:** asserting `a_rst` in any state, including mid-VECTOR or WAIT_SF, returns to RESET on the next edge. Pending latches are discarded.

## Timing
- **Acks:** `nmi_ack`/`irq_ack` are a one-cycle pulse in the cycle whose next state is VECTOR. At most one bit is set. No ack is issued for brk or rst.
- **Replace:** `replace_ir` = `replace_k` = (state == VECTOR).
- **Holds:**
  - `hold_fetch` = (next ≠ RUN).
  - `hold_decode` = (next ∉ {VECTOR, RUN}).
- **Latency:** request in RUN with `feed_ack` → VECTOR next cycle → first RUN cycle at least 3 cycles later.
- **Busy/ready race:** `sf_busy` and `sf_rdy` in the same cycle leave the group busy.

## Configuration
- **`CPU_INT_NMI_EDGE_EN`:**
  - Defined: NMI is rising-edge detected into a pending latch. The latch is cleared only on `nmi_ack`, so a one-cycle pulse is never lost.
  - Undefined: NMI is level-sensitive, with no latch.

## Structure
- Package `cpu_int_pkg` holds:
  - the state enum;
  - the source-ID constants;
  - the opcode constants 16'h132C and 16'h8322;
  - the vector offset constants.
- One sub-module, `cpu_sf_scoreboard`: one instance per flag group, holding `sf_status`.

## Test plan
- **Reset:** `a_rst` held 2 cycles → state RESET, `hold_fetch` = 1, `i_flag` = 1. Then VECTOR with `int_k` = 16'hFFFC and `int_ir` = 16'h132C.
- **IRQ priority:** `ien` = 4'b1111, `i_flag` = 0, `irq` = 4'b0110 in RUN with `feed_ack` → `irq_ack` = 4'b0010 and `int_k` = 16'hFFF0. `i_flag` = 1 next cycle.
- **NMI over IRQ:** `nmi` and `irq[0]` asserted together → `nmi_ack` pulses once, `int_k` = 16'hFFFA, `irq_ack` = 0.
- **Flag stall:** `sf_busy[1]` then `sf_query` = 2'b10 → WAIT_SF with `hold_decode` = 1. `sf_rdy[1]` → RUN next cycle.
- **WAI with masked IRQ:** `op_wai`, then `irq[2]` while `i_flag` = 1 → stays WAIT_INT. `op_cli` is not decoded here, so a later `nmi` → VECTOR with `int_k` = 16'hFFFA.
- **Edge NMI** (with `CPU_INT_NMI_EDGE_EN`): 1-cycle `nmi` pulse during WAIT_SF → NMI still taken after return to RUN.
